// File: rtl/mux_scan_sequencer.sv
// rtl/mux_scan_sequencer.sv - walks an external mux select through every slot and gathers the samples into one frame
module mux_scan_sequencer #(
    parameter int WIDTH  = 4,
    parameter int SWIDTH = 4,
    parameter int HOLD   = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         abort,
    input  logic [WIDTH-1:0]             din,
    output logic [SWIDTH-1:0]            sel,
    output logic                         busy,
    output logic                         done,
    output logic [WIDTH*(1<<SWIDTH)-1:0] frame
);

    localparam int N  = 1 << SWIDTH;
    localparam int FW = WIDTH * N;
    localparam logic [SWIDTH-1:0] LAST_SEL  = SWIDTH'(N - 1);
    localparam logic [3:0]        HOLD_LAST = 4'(HOLD - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t            state, state_n;
    logic [SWIDTH-1:0] sel_n;
    logic [3:0]        hold_cnt, hold_n;
    logic              busy_n, done_n;
    logic [FW-1:0]     shadow, shadow_n, frame_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            sel      <= '0;
            hold_cnt <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            shadow   <= '0;
            frame    <= '0;
        end else begin
            state    <= state_n;
            sel      <= sel_n;
            hold_cnt <= hold_n;
            busy     <= busy_n;
            done     <= done_n;
            shadow   <= shadow_n;
            frame    <= frame_n;
        end
    end

    always_comb begin
        state_n  = state;
        sel_n    = sel;
        hold_n   = hold_cnt;
        busy_n   = busy;
        done_n   = 1'b0;
        shadow_n = shadow;
        frame_n  = frame;
        case (state)
            IDLE, DONE: begin
                sel_n   = '0;
                hold_n  = '0;
                busy_n  = 1'b0;
                state_n = IDLE;
                if (start && !abort) begin
                    state_n = SCAN;
                    busy_n  = 1'b1;
                end
            end
            SCAN: begin
                // abort wins even over the final sample on the same edge
                if (abort) begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                    sel_n   = '0;
                    hold_n  = '0;
                end else if (hold_cnt == HOLD_LAST) begin
                    shadow_n[int'(sel)*WIDTH +: WIDTH] = din;
                    hold_n = '0;
                    if (sel == LAST_SEL) begin
                        state_n = DONE;
                        frame_n = shadow_n;
                        done_n  = 1'b1;
                        busy_n  = 1'b0;
                        sel_n   = '0;
                    end else begin
                        sel_n = sel + 1'b1;
                    end
                end else begin
                    hold_n = hold_cnt + 4'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule
